// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared types and constants for the OV7670 stream generator
package ov7670_pkg;

  typedef enum logic [2:0] {IDLE, VS, VBP, ACT, VFP} state_t;

  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_GRAD  = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = RGB_WHITE;
      3'd1:    bar_color = RGB_YELLOW;
      3'd2:    bar_color = RGB_CYAN;
      3'd3:    bar_color = RGB_GREEN;
      3'd4:    bar_color = RGB_MAGENTA;
      3'd5:    bar_color = RGB_RED;
      3'd6:    bar_color = RGB_BLUE;
      default: bar_color = RGB_BLACK;
    endcase
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/ov7670_stream_gen_pattern.sv
// rtl/ov7670_stream_gen_pattern.sv - combinational test-pattern byte generator
module ov7670_pattern
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = 160,
  parameter int XW       = 8,
  parameter int YW       = 7
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [1:0]    pat_sel,
  input  logic [15:0]   color,
  input  logic          frame_parity,
  input  logic          byte_phase,
  output logic [7:0]    d
);

  logic [2:0]  bar;
  logic        cx;
  logic        cy;
  logic [15:0] pix;

  always_comb begin
    bar = 3'((16'(x) << 3) / 16'(H_ACTIVE));
    cx  = 1'(x >> 3);
    cy  = 1'(y >> 3);
    case (pat_sel)
      PAT_SOLID: pix = color;
      PAT_BARS:  pix = bar_color(bar);
      PAT_GRAD:  pix = {5'(x), 6'(x), 5'(y)};
      default:   pix = (cx ^ cy ^ frame_parity) ? RGB_WHITE : RGB_BLACK;
    endcase
    // RGB565 high byte goes out first
    d = byte_phase ? pix[7:0] : pix[15:8];
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// rtl/ov7670_stream_gen.sv - OV7670-style PCLK/VSYNC/HREF/D frame transmitter
module ov7670_stream_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE  = 160,
  parameter int V_ACTIVE  = 120,
  parameter int H_BLANK   = 16,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 2,
  parameter int VFP_LINES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pat_sel,
  input  logic [15:0] color,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_done,
  output logic        busy
);

  localparam int L  = 2 * H_ACTIVE + H_BLANK;
  localparam int BW = $clog2(L);
  localparam int LW = $clog2(max4(V_ACTIVE, VS_LINES, VBP_LINES, VFP_LINES) + 1);
  localparam int XW = $clog2(H_ACTIVE);

  state_t          state, n_state;
  logic [BW-1:0]   bcnt, n_b;
  logic [LW-1:0]   lcnt, n_l, lines_lim;
  logic [1:0]      pat_q;
  logic [15:0]     color_q;
  logic            frame_cnt;
  logic            end_line, end_state, done, start, n_href;
  logic [7:0]      pix_byte;

  // Next position/state for the PCLK period that begins at the coming falling edge
  always_comb begin
    case (state)
      VS:      lines_lim = LW'(VS_LINES);
      VBP:     lines_lim = LW'(VBP_LINES);
      ACT:     lines_lim = LW'(V_ACTIVE);
      VFP:     lines_lim = LW'(VFP_LINES);
      default: lines_lim = '0;
    endcase
    end_line  = (bcnt == BW'(L - 1));
    end_state = end_line && (lcnt == lines_lim - 1'b1);
    n_b       = end_line ? '0 : bcnt + 1'b1;
    n_l       = end_line ? lcnt + 1'b1 : lcnt;
    n_state   = state;
    done      = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        n_b = '0;
        n_l = '0;
        if (en) begin
          n_state = VS;
          start   = 1'b1;
        end
      end
      VS:  if (end_state) begin n_state = VBP; n_l = '0; end
      VBP: if (end_state) begin n_state = ACT; n_l = '0; end
      ACT: if (end_state) begin n_state = VFP; n_l = '0; end
      VFP: if (end_state) begin
        n_l  = '0;
        done = 1'b1;
        if (en) begin
          n_state = VS;
          start   = 1'b1;
        end else begin
          n_state = IDLE;
        end
      end
      default: n_state = IDLE;
    endcase
    n_href = (n_state == ACT) && (n_b < BW'(2 * H_ACTIVE));
  end

  ov7670_pattern #(
    .H_ACTIVE(H_ACTIVE),
    .XW      (XW),
    .YW      (LW)
  ) u_pattern (
    .x           (n_b[XW:1]),
    .y           (n_l),
    .pat_sel     (pat_q),
    .color       (color_q),
    .frame_parity(frame_cnt),
    .byte_phase  (n_b[0]),
    .d           (pix_byte)
  );

  // All sync/data updates happen on the edge where pclk falls, so they are stable at its rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk       <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      d          <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      state      <= IDLE;
      bcnt       <= '0;
      lcnt       <= '0;
      pat_q      <= '0;
      color_q    <= '0;
      frame_cnt  <= 1'b0;
    end else begin
      pclk       <= ~pclk;
      frame_done <= 1'b0;
      if (pclk) begin
        state      <= n_state;
        bcnt       <= n_b;
        lcnt       <= n_l;
        vsync      <= (n_state == VS);
        href       <= n_href;
        d          <= n_href ? pix_byte : 8'h00;
        busy       <= (n_state != IDLE);
        frame_done <= done;
        if (done) frame_cnt <= ~frame_cnt;
        if (start) begin
          pat_q   <= pat_sel;
          color_q <= color;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb/tb_ov7670_stream_gen.sv - scoreboard bench for the OV7670 stream generator
module tb_ov7670_stream_gen;

  localparam int HA   = 40;
  localparam int VA   = 20;
  localparam int HB   = 4;
  localparam int VSL  = 3;
  localparam int VBPL = 2;
  localparam int VFPL = 2;
  localparam int L    = 2 * HA + HB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  pat_sel = 2'd0;
  logic [15:0] color = 16'h0000;
  logic        pclk, vsync, href, frame_done, busy;
  logic [7:0]  d;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  int parity = 0;

  int   hcount = 0;
  int   run = 0;
  logic [1:0] prev = 2'b00;
  bit   first_href = 1'b1;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  ov7670_stream_gen #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_BLANK  (HB),
    .VS_LINES (VSL),
    .VBP_LINES(VBPL),
    .VFP_LINES(VFPL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pat_sel   (pat_sel),
    .color     (color),
    .pclk      (pclk),
    .vsync     (vsync),
    .href      (href),
    .d         (d),
    .frame_done(frame_done),
    .busy      (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pixel(input int pat, input logic [15:0] col,
                                              input int x, input int y, input int par);
    logic [15:0] bars [8];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    case (pat)
      0: return col;
      1: return bars[x * 8 / HA];
      2: return 16'(((x % 32) << 11) | ((x % 64) << 5) | (y % 32));
      default: return ((((x / 8) % 2) ^ ((y / 8) % 2) ^ par) != 0) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  task automatic push_frame(input int pat, input logic [15:0] col);
    logic [15:0] p;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++) begin
        p = model_pixel(pat, col, x, y, parity);
        sb.push_back(p[15:8]);
        sb.push_back(p[7:0]);
      end
    parity ^= 1;
  endtask

  task automatic wait_busy();
    bit got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (busy) got = 1'b1;
    end
    chk("busy_rise", got, 1);
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (frame_done) got = 1'b1;
    end
    chk("frame_done_seen", got, 1);
  endtask

  // Monitor: one sample per PCLK period (pclk high), plus FRAME_DONE at CLK resolution
  always @(negedge clk) begin
    logic [1:0] cur;
    if (!rst_n) begin
      prev = 2'b00; run = 0; hcount = 0; first_href = 1'b1; prev_done = 1'b0;
      sb.delete();
    end else begin
      if (frame_done) begin
        chk("done_width", prev_done, 0);
        chk("frame_lines", hcount, VA);
        chk("vfp_len", run, HB + VFPL * L);
        hcount = 0;
      end
      prev_done = frame_done;
      if (pclk) begin
        cur = {vsync, href};
        if (vsync) chk("vs_href_overlap", href, 0);
        if (!href) chk("d_blank", d, 0);
        else if (sb.size() == 0) chk("sb_nonempty", sb.size(), 1);
        else chk("pixel_byte", d, sb.pop_front());
        if (cur == prev) run++;
        else begin
          case (prev)
            2'b10: chk("vs_len", run, VSL * L);
            2'b01: begin chk("href_len", run, 2 * HA); hcount++; end
            2'b00: if (cur == 2'b01) begin
              if (first_href) chk("vbp_len", run, VBPL * L);
              else chk("hblank_len", run, HB);
              first_href = 1'b0;
            end
            default: ;
          endcase
          if (cur[1]) first_href = 1'b1;
          run  = 1;
          prev = cur;
        end
      end
    end
  end

  initial begin
    logic lp;
    int p;
    logic [15:0] c;
    bit got;

    repeat (3) @(negedge clk);
    chk("rst_pclk", pclk, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_href", href, 0);
    chk("rst_d", d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    rst_n = 1'b1;
    lp = pclk;
    repeat (100) begin
      @(negedge clk);
      chk("pclk_toggle", pclk, !lp);
      lp = pclk;
    end
    chk("idle_busy", busy, 0);
    chk("idle_vsync", vsync, 0);

    // Solid colour, then mid-frame PAT_SEL change only affects the following frame
    pat_sel = 2'd0; color = 16'hF81F;
    push_frame(0, 16'hF81F);
    en = 1'b1;
    wait_busy();
    chk("start_vsync", vsync, 1);
    pat_sel = 2'd1; color = 16'($urandom);
    push_frame(1, color);
    wait_done();
    pat_sel = 2'd2; color = 16'($urandom);
    push_frame(2, color);
    wait_done();

    // EN dropped mid-active: frame still completes
    pat_sel = 2'd3;
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (hcount >= 10) got = 1'b1;
    end
    chk("reach_line10", got, 1);
    en = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("stop_busy", busy, 0);
    chk("sb_drained", sb.size(), 0);

    // Checkerboard on an odd-parity frame, then random patterns
    push_frame(3, 16'h0000);
    en = 1'b1;
    wait_busy();
    en = 1'b0;
    wait_done();
    for (int k = 0; k < 2; k++) begin
      p = int'($urandom_range(0, 3));
      c = 16'($urandom);
      pat_sel = 2'(p); color = c;
      push_frame(p, c);
      en = 1'b1;
      wait_busy();
      en = 1'b0;
      wait_done();
    end
    repeat (4) @(negedge clk);
    chk("sb_drained2", sb.size(), 0);

    // Asynchronous reset in the middle of active line 10
    pat_sel = 2'(int'($urandom_range(0, 3))); color = 16'($urandom);
    push_frame(int'(pat_sel), color);
    en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (hcount == 10 && href) got = 1'b1;
    end
    chk("reach_href10", got, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pclk", pclk, 0);
    chk("arst_href", href, 0);
    chk("arst_vsync", vsync, 0);
    chk("arst_d", d, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", frame_done, 0);
    repeat (2) @(negedge clk);
    parity = 0;
    rst_n = 1'b1;
    p = int'($urandom_range(0, 3));
    c = 16'($urandom);
    pat_sel = 2'(p); color = c;
    push_frame(p, c);
    wait_busy();
    chk("restart_vsync", vsync, 1);
    en = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("sb_drained3", sb.size(), 0);
    chk("end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
